// File: rtl/clint_responder_pkg.sv
// Shared CLINT configuration: address window, RTC divider, register offsets and FSM state type.
package clint_responder_pkg;

  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr  = 32'h0200_BFFF;
  localparam int unsigned clk_freq        = 1_000_000_000;
  localparam int unsigned rtc_freq        = 100_000_000;
  localparam int unsigned clk_divider_rtc = clk_freq / (2 * rtc_freq) - 1;

  localparam logic [15:0] clint_msip_off     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
  localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } clint_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_responder_rtc_tick.sv
// RTC generator: divides the core clock into an rtc square wave and emits a
// one-cycle tick on each rising edge of rtc.
module clint_rtc_tick #(
  parameter int unsigned clk_divider_rtc = 4
) (
  input  logic reset,
  input  logic clock,
  output logic tick
);

  localparam int unsigned CW = (clk_divider_rtc < 1) ? 1 : $clog2(clk_divider_rtc + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rtc_q, rtc_d;
  logic          rtc_prev_q, rtc_prev_d;
  logic          terminal;

  always_comb begin
    terminal   = (cnt_q == CW'(clk_divider_rtc));
    cnt_d      = terminal ? '0 : cnt_q + CW'(1);
    rtc_d      = rtc_q ^ terminal;
    rtc_prev_d = rtc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      rtc_q      <= 1'b0;
      rtc_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rtc_q      <= rtc_d;
      rtc_prev_q <= rtc_prev_d;
    end
  end

  assign tick = rtc_q & ~rtc_prev_q;

endmodule

// File: rtl/clint_responder.sv
// CLINT bus responder: msip, mtimecmp and mtime registers with a 1-cycle handshake.
// Define CLINT_MTIME_WRITE_EN to make mtime writable; otherwise mtime is read-only.
module clint_responder #(
  parameter logic [31:0] clint_base_addr = clint_responder_pkg::clint_base_addr,
  parameter int unsigned clk_divider_rtc = clint_responder_pkg::clk_divider_rtc
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        clint_valid,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip
);

  import clint_responder_pkg::*;

  clint_state_e state_q, state_d;
  logic         msip_q, msip_d;
  logic [63:0]  mtimecmp_q, mtimecmp_d;
  logic [63:0]  mtime_q, mtime_d;
  logic         mtip_q, mtip_d;
  logic [31:0]  rdata_q, rdata_d;

  logic        tick;
  logic [31:0] off_full;
  logic [15:0] off;
  logic [31:0] rd_val;
  logic [63:0] mtime_inc;
  logic        unused_addr_bits;

  clint_rtc_tick #(
    .clk_divider_rtc(clk_divider_rtc)
  ) u_rtc_tick (
    .reset(reset),
    .clock(clock),
    .tick (tick)
  );

  assign off_full         = clint_addr - clint_base_addr;
  assign off              = {off_full[15:2], 2'b00};
  assign unused_addr_bits = ^{off_full[31:16], off_full[1:0]};
  assign mtime_inc        = mtime_q + 64'(tick);

  always_comb begin
    rd_val = '0;
    case (off)
      clint_msip_off:             rd_val[0] = msip_q;
      clint_mtimecmp_off:         rd_val    = mtimecmp_q[31:0];
      clint_mtimecmp_off + 16'd4: rd_val    = mtimecmp_q[63:32];
      clint_mtime_off:            rd_val    = mtime_q[31:0];
      clint_mtime_off + 16'd4:    rd_val    = mtime_q[63:32];
      default:                    rd_val    = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_inc;
    rdata_d    = rdata_q;
    mtip_d     = (mtime_q >= mtimecmp_q);

    case (state_q)
      ST_IDLE: begin
        if (clint_valid) begin
          state_d = ST_RESP;
          rdata_d = rd_val;
          // Written bytes override the ticked mtime; unwritten bytes keep the increment.
          case (off)
            clint_msip_off:
              if (clint_wstrb[0]) msip_d = clint_wdata[0];
            clint_mtimecmp_off:
              mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
            clint_mtimecmp_off + 16'd4:
              mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
`ifdef CLINT_MTIME_WRITE_EN
            clint_mtime_off:
              mtime_d[31:0] = merge_bytes(mtime_inc[31:0], clint_wdata, clint_wstrb);
            clint_mtime_off + 16'd4:
              mtime_d[63:32] = merge_bytes(mtime_inc[63:32], clint_wdata, clint_wstrb);
`endif
            default: ;
          endcase
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      mtip_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = (state_q == ST_RESP);
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;

endmodule

// File: doc/clint_responder.md
Name: clint_responder

Overview:
- Memory-mapped core-local interruptor (CLINT) that answers CPU data-bus requests in the window 0x2000000-0x200BFFF.
- Owns the machine software-interrupt bit (msip), the 64-bit timer compare register (mtimecmp) and the 64-bit real-time counter (mtime).
- mtime advances on an RTC tick derived from the core clock: 1 GHz core, 100 MHz RTC.
- Drives the msip and mtip interrupt lines into the core's CSR unit.

Parameters:
- clint_base_addr, 32'h2000000: base of the CLINT window; the bus decoder guarantees addresses within 0x200BFFF.
- clk_divider_rtc, 4: half-period of the RTC in core cycles, minus 1. Default gives an RTC period of 10 core cycles.

Ports:
- reset  in  1  synchronous, active-high
- clock  in  1  core clock
- clint_valid  in  1  request strobe; held until clint_ready
- clint_addr  in  32  byte address; bits [1:0] ignored
- clint_wdata  in  32  write data
- clint_wstrb  in  4  byte enables; 0 means read
- clint_rdata  out  32  read data, valid while clint_ready=1
- clint_ready  out  1  one-cycle completion pulse
- clint_msip  out  1  software interrupt pending
- clint_mtip  out  1  timer interrupt pending

Behaviour:
- Register map (offset = addr - clint_base_addr):
  - 0x0000: msip; bit0 R/W, bits 31:1 read 0.
  - 0x4000 / 0x4004: mtimecmp low / high.
  - 0xBFF8 / 0xBFFC: mtime low / high.
  - Any other offset: reads 0, writes ignored, clint_ready still pulses.
- Reset values:
  - msip = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, mtime = 0.
  - Divider counter = 0, rtc level = 0.
  - clint_ready = 0, clint_rdata = 0, clint_mtip = 0, clint_msip = 0.
- Handshake:
  - Two-state FSM, IDLE -> RESP -> IDLE.
  - In IDLE with clint_valid=1: latch the request and perform any write at the end of that cycle. Go to RESP.
  - In RESP: clint_ready=1 and clint_rdata holds the read value sampled in the IDLE cycle. Return to IDLE.
  - Latency is exactly 1 cycle. Back-to-back requests complete every 2 cycles.
  - clint_valid is not sampled in RESP.
- Writes are byte-granular per clint_wstrb. Untouched bytes keep their value.
- Read of the mtime halves returns the value before any tick in the same cycle. Software handles the hi/lo rollover race.
- RTC divider:
  - Counter counts 0..clk_divider_rtc. At terminal count it reloads 0 and toggles rtc.
  - A tick is the rising edge of rtc, detected with a registered copy of rtc.
  - Each tick adds 1 to mtime, carrying from bit 31 into bit 32. mtime wraps from all-ones to 0.
- Simultaneous mtime write and tick: the written bytes take the written data. Unwritten bytes take the incremented value.
- clint_mtip is registered and equals (mtime >= mtimecmp), unsigned 64-bit. It updates one cycle after either operand changes.
- clint_msip equals the msip register bit directly.
- Reset asserted mid-transaction: the FSM returns to IDLE, clint_ready drops next cycle, and the pending write is lost.

Optional Feature:
- Macro: CLINT_MTIME_WRITE_EN.
- Defined: mtime at 0xBFF8/0xBFFC is writable as described above.
- Not defined: mtime is read-only. Writes to it complete with clint_ready but do not change it, and ticks are unaffected.

Decomposition:
- Shared configure package holds:
  - clint_base_addr, clint_top_addr, clk_freq, rtc_freq and clk_divider_rtc;
  - offset constants clint_msip_off, clint_mtimecmp_off and clint_mtime_off.
- One sub-module, clint_rtc_tick: divider counter, rtc toggle and edge detect, producing a 1-cycle tick output. It has its own reset and clock.

Test Plan:
- Reset, then read 0x200BFF8 -> clint_rdata 0, clint_ready exactly 1 cycle after valid.
  - Idle 100 cycles, then read again -> 10.
- Write 1 with wstrb 4'b0001 to 0x2000000 -> clint_msip=1 next cycle. Read returns 32'h1.
  - Write 0 -> clint_msip=0.
- Write mtimecmp lo=20, hi=0 -> clint_mtip rises within 1 cycle of mtime reaching 20 (about 200 cycles from reset).
  - Then write mtimecmp hi=1 -> mtip falls the following cycle.
- With CLINT_MTIME_WRITE_EN, write mtime lo=32'hFFFFFFFF, hi=0 -> after the next tick, reading hi returns 1 and lo returns 0.
  - Without the macro, the same writes leave mtime counting from its prior value.
- Write 32'hAABBCCDD with wstrb 4'b0100 to 0x2004000 -> mtimecmp lo reads 32'hFFBBFFFF.
  - Read offset 0x1000 -> 0, ready asserted.
- Assert reset in the RESP cycle of a write to mtimecmp -> after reset, mtimecmp=all-ones, clint_ready=0, mtip=0.
